// File: rtl/aes_out_serializer_pkg.sv
// Shared types and constants for the AES ciphertext output serializer.
// Optional parity output is enabled by defining AES_OUT_PARITY_EN.
package aes_out_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_BLK = 4;
    localparam int unsigned BLK_W         = WORD_W * WORDS_PER_BLK;

    typedef enum logic [0:0] {StIdle, StSend} ser_state_e;

    typedef logic [1:0] word_idx_t;

    // Most-significant word goes out first.
    function automatic logic [WORD_W-1:0] blk_word(input logic [BLK_W-1:0] blk,
                                                   input word_idx_t idx);
        logic [WORD_W-1:0] w;
        unique case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_out_serializer_if.sv
// Word stream from the serializer to a narrow consumer.
// ser_parity exists only when AES_OUT_PARITY_EN is defined.
interface aes_out_serializer_if;

    logic [aes_out_pkg::WORD_W-1:0] ser_data;
    logic                           ser_valid;
    logic                           ser_ready;
    logic                           ser_last;
`ifdef AES_OUT_PARITY_EN
    logic                           ser_parity;
`endif

    modport master (
        output ser_data,
        output ser_valid,
        output ser_last,
`ifdef AES_OUT_PARITY_EN
        output ser_parity,
`endif
        input  ser_ready
    );

    modport slave (
        input  ser_data,
        input  ser_valid,
        input  ser_last,
`ifdef AES_OUT_PARITY_EN
        input  ser_parity,
`endif
        output ser_ready
    );

endinterface

// File: rtl/aes_blk_fifo.sv
// DEPTH x 128-bit block FIFO; exposes the head entry and the entry behind it
// so the serializer can start the next block without a bubble.
module aes_blk_fifo
    import aes_out_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [BLK_W-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [BLK_W-1:0] head_o,
    output logic [BLK_W-1:0] next_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [BLK_W-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next_idx;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + LW'(1);
        if (rd_en_i) rd_ptr_d = rd_ptr_q + LW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

    assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
    assign head_o      = mem_q[rd_ptr_q[AW-1:0]];
    assign next_o      = mem_q[rd_next_idx];
    assign level_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (level_o == LW'(DEPTH));

endmodule

// File: rtl/aes_out_serializer.sv
// Captures AES ciphertext blocks on the valid rising edge and streams them as
// 32-bit words, MSW first. AES_OUT_PARITY_EN adds a registered ser_parity output.
module aes_out_serializer
    import aes_out_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic                  AES_clk,
    input  logic                  AES_rst,
    input  logic [BLK_W-1:0]      AES_data_out,
    input  logic                  AES_data_out_valid,
    aes_out_serializer_if.master  ser,
    output logic [LW-1:0]         fifo_level,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    ser_state_e        state_q, state_d;
    word_idx_t         idx_q, idx_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              in_valid_q;
    logic              overflow_q, overflow_d;

    logic              capture, wr_en, drop, pop, fire;
    logic              full, empty;
    logic [BLK_W-1:0]  head, nxt;

    assign capture = AES_data_out_valid & ~in_valid_q;
    // A full FIFO still takes a block if the head leaves on the same edge.
    assign wr_en   = capture & (~full | pop);
    assign drop    = capture & full & ~pop;
    assign fire    = valid_q & ser.ser_ready;

    aes_blk_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (AES_clk),
        .rst_i     (AES_rst),
        .wr_en_i   (wr_en),
        .wr_data_i (AES_data_out),
        .rd_en_i   (pop),
        .head_o    (head),
        .next_o    (nxt),
        .full_o    (full),
        .empty_o   (empty),
        .level_o   (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StSend;
                    idx_d   = 2'd0;
                    data_d  = blk_word(head, 2'd0);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            StSend: begin
                if (fire) begin
                    if (idx_q == 2'd3) begin
                        pop = 1'b1;
                        if (fifo_level > LW'(1)) begin
                            idx_d  = 2'd0;
                            data_d = blk_word(nxt, 2'd0);
                            last_d = 1'b0;
                        end else begin
                            state_d = StIdle;
                            data_d  = '0;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = blk_word(head, idx_d);
                        last_d = (idx_d == 2'd3);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (overflow_clr) overflow_d = 1'b0;
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state_q    <= StIdle;
            idx_q      <= 2'd0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            in_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            in_valid_q <= AES_data_out_valid;
            overflow_q <= overflow_d;
        end
    end

    assign ser.ser_data  = data_q;
    assign ser.ser_valid = valid_q;
    assign ser.ser_last  = last_q;
    assign overflow      = overflow_q;

`ifdef AES_OUT_PARITY_EN
    logic parity_q;

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) parity_q <= 1'b0;
        else         parity_q <= ^data_d;
    end

    assign ser.ser_parity = parity_q;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_aes_out_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [127:0]   din = '0;
    logic           din_v = 1'b0;
    logic [LW-1:0]  level;
    logic           ovf;
    logic           ovf_clr = 1'b0;

    aes_out_serializer_if ser_if ();

    always #5 clk = ~clk;

    aes_out_serializer #(
        .DEPTH (DEPTH)
    ) dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_data_out       (din),
        .AES_data_out_valid (din_v),
        .ser                (ser_if.master),
        .fifo_level         (level),
        .overflow           (ovf),
        .overflow_clr       (ovf_clr)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        par;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_word(input logic [31:0] w, input logic last);
        exp_t e;
        e.data = w;
        e.last = last;
        e.par  = ^w;
        sb.push_back(e);
    endtask

    task automatic push_blk(input logic [127:0] b);
        for (int i = 0; i < 4; i++) push_word(b[127-32*i -: 32], i == 3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_blk(input logic [127:0] b);
        din   = b;
        din_v = 1'b1;
        tick();
        din_v = 1'b0;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ser_if.ser_valid && n < 20) begin
            tick();
            n++;
        end
        if (!ser_if.ser_valid) check_eq(name, 0, 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check_eq(name, 128'(sb.size()), 0);
    endtask

    // Monitor: compare accepted words, and hold data steady across stalls.
    logic        stalled = 1'b0;
    logic [31:0] st_data;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("stall_valid", ser_if.ser_valid, 1);
                check_eq("stall_data", ser_if.ser_data, st_data);
            end
            if (ser_if.ser_valid && ser_if.ser_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_word", ser_if.ser_data, 0);
                    if (ser_if.ser_data == 0) $display("FAIL unexpected_word: zero word");
                end else begin
                    e = sb.pop_front();
                    check_eq("word", ser_if.ser_data, e.data);
                    check_eq("last", ser_if.ser_last, e.last);
`ifdef AES_OUT_PARITY_EN
                    check_eq("parity", ser_if.ser_parity, e.par);
`endif
                end
                stalled = 1'b0;
            end else if (ser_if.ser_valid) begin
                stalled = 1'b1;
                st_data = ser_if.ser_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    logic [127:0] blks [5];
    logic [127:0] b;
    int           found;

    initial begin
        ser_if.ser_ready = 1'b0;
        blks[0] = 128'h11111111_22222222_33333333_44444444;
        blks[1] = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
        blks[2] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        blks[3] = 128'hDEADBEEF_CAFEF00D_0BADC0DE_FACEB00C;
        blks[4] = 128'h55555555_66666666_77777777_88888888;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", ser_if.ser_valid, 0);
        check_eq("rst_last", ser_if.ser_last, 0);
        check_eq("rst_data", ser_if.ser_data, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // 1: single pulse, back-to-back words, latency and level
        ser_if.ser_ready = 1'b1;
        b = 128'h3925841d_02dc09fb_dc118597_196a0b32;
        push_blk(b);
        din   = b;
        din_v = 1'b1;
        tick();
        din_v = 1'b0;
        check_eq("t1_level1", level, 1);
        check_eq("t1_not_yet_valid", ser_if.ser_valid, 0);
        tick();
        check_eq("t1_latency_valid", ser_if.ser_valid, 1);
        check_eq("t1_word0", ser_if.ser_data, 32'h3925841d);
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_nogap", ser_if.ser_valid, 1);
            tick();
        end
        check_eq("t1_level0", level, 0);
        check_eq("t1_idle", ser_if.ser_valid, 0);

        // 2: held valid captures once
        push_blk(blks[2]);
        din   = blks[2];
        din_v = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_level_le1", level <= LW'(1), 1);
        end
        din_v = 1'b0;
        drain("t2_drain");
        repeat (3) tick();
        check_eq("t2_once", ser_if.ser_valid, 0);

        // 3: overflow with stalled consumer, then ordered drain
        ser_if.ser_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) push_blk(blks[k]);
            pulse_blk(blks[k]);
        end
        check_eq("t3_level4", level, 4);
        check_eq("t3_ovf_set", ovf, 1);
        ser_if.ser_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("t3_nogap", ser_if.ser_valid, 1);
            tick();
        end
        check_eq("t3_level0", level, 0);
        check_eq("t3_ovf_sticky", ovf, 1);
        check_eq("t3_sb_empty", 128'(sb.size()), 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_eq("t3_ovf_clr", ovf, 0);

        // 4: write to a full FIFO on the same edge the head is popped
        ser_if.ser_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_blk(blks[k]);
            pulse_blk(blks[k]);
        end
        check_eq("t4_full", level, 4);
        ser_if.ser_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            tick();
            if (ser_if.ser_valid && ser_if.ser_last) found = 1;
        end
        check_eq("t4_reach_last", found, 1);
        push_blk(blks[4]);
        din   = blks[4];
        din_v = 1'b1;
        tick();
        din_v = 1'b0;
        check_eq("t4_level_stays4", level, 4);
        check_eq("t4_no_ovf", ovf, 0);
        drain("t4_drain");

        // 5: random backpressure
        push_blk(blks[1]);
        push_blk(blks[3]);
        pulse_blk(blks[1]);
        pulse_blk(blks[3]);
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            ser_if.ser_ready = 1'($urandom_range(0, 1));
            tick();
        end
        ser_if.ser_ready = 1'b1;
        drain("t5_drain");

        // 6: reset during word 2
        ser_if.ser_ready = 1'b0;
        b = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
        push_word(32'h0A0B0C0D, 1'b0);
        push_word(32'h1A1B1C1D, 1'b0);
        pulse_blk(b);
        wait_valid("t6_start");
        ser_if.ser_ready = 1'b1;
        tick();
        tick();
        ser_if.ser_ready = 1'b0;
        tick();
        check_eq("t6_idx2", ser_if.ser_data, 32'h2A2B2C2D);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", ser_if.ser_valid, 0);
        check_eq("t6_rst_level", level, 0);
        check_eq("t6_sb_consumed", 128'(sb.size()), 0);
        tick();
        rst = 1'b0;
        ser_if.ser_ready = 1'b1;
        tick();
        push_blk(blks[0]);
        pulse_blk(blks[0]);
        drain("t6_drain");

`ifdef AES_OUT_PARITY_EN
        // 7: parity per word
        push_blk(128'h00000001_00000003_00000000_ffffffff);
        pulse_blk(128'h00000001_00000003_00000000_ffffffff);
        drain("t7_drain");
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
